// File: rtl/abr_params_pkg.sv
// abr_params_pkg
// Shared ML-DSA constants for the UseHint datapath.
//   MLDSA_Q        field modulus q
//   MLDSA_GAMMA2   low-order rounding range (q-1)/32
//   MLDSA_ALPHA    decomposition step 2*GAMMA2
//   MLDSA_OMEGA    maximum number of set hint bits per signature
//   MLDSA_W1_WIDTH width of one w1 coefficient
//   MLDSA_R1_MAX   largest raw r1 before the q-1 wrap folds it back to 0
//   usehint_w1_t   one w1 coefficient
package abr_params_pkg;

  localparam int MLDSA_Q        = 8380417;
  localparam int MLDSA_GAMMA2   = 261888;
  localparam int MLDSA_ALPHA    = 2 * MLDSA_GAMMA2;
  localparam int MLDSA_OMEGA    = 75;
  localparam int MLDSA_W1_WIDTH = 4;
  localparam int MLDSA_R1_MAX   = (MLDSA_Q - 1) / MLDSA_ALPHA;

  typedef logic [MLDSA_W1_WIDTH-1:0] usehint_w1_t;

endpackage

// File: rtl/usehint_lane.sv
// usehint_lane
// Purely combinational UseHint for one coefficient, split at the S1 boundary.
// The decompose half runs before S1; the hint-apply half runs on S1 values.
// Ports:
//   r          in   REG_SIZE  coefficient in [0, q-1]
//   r1         out  5         high part (0..15 after the q-1 wrap)
//   r0_pos     out  1         low part r0 is strictly positive
//   s1_r1      in   5         registered r1
//   s1_r0_pos  in   1         registered r0_pos
//   s1_h       in   1         registered hint bit
//   w1         out  4         hint-adjusted high part, mod 16
module usehint_lane
  import abr_params_pkg::*;
#(
  parameter int REG_SIZE = 23
) (
  input  logic [REG_SIZE-1:0] r,
  output logic [4:0]          r1,
  output logic                r0_pos,
  input  logic [4:0]          s1_r1,
  input  logic                s1_r0_pos,
  input  logic                s1_h,
  output usehint_w1_t         w1
);

  logic [4:0]              r1_raw;
  logic signed [REG_SIZE:0] r0;

  // r1 = floor(r/alpha) rounded up when r mod alpha > GAMMA2, which is the
  // same as counting how many thresholds (2k-1)*GAMMA2 lie strictly below r.
  // This avoids a real divider.
  always_comb begin
    r1_raw = '0;
    for (int k = 1; k <= MLDSA_R1_MAX; k++) begin
      if (r > REG_SIZE'((2 * k - 1) * MLDSA_GAMMA2)) begin
        r1_raw = r1_raw + 5'd1;
      end
    end
  end

  // r0 = r - r1*alpha. Raw r1 == 16 means r - r0 == q-1, which folds to
  // r1 = 0 with r0 decremented (r0 is then always negative).
  always_comb begin
    r0 = $signed({1'b0, r}) - $signed({1'b0, REG_SIZE'(r1_raw * MLDSA_ALPHA)});
    r1 = r1_raw;
    if (r1_raw == 5'(MLDSA_R1_MAX)) begin
      r1 = '0;
      r0 = r0 - (REG_SIZE + 1)'(1);
    end
    r0_pos = ~r0[REG_SIZE] & (|r0);
  end

  // Hint step: nudge r1 toward the side r0 leans, wrapping mod 16.
  always_comb begin
    w1 = usehint_w1_t'(s1_r1);
    if (s1_h) begin
      if (s1_r0_pos) begin
        w1 = usehint_w1_t'(s1_r1 + 5'd1);
      end else begin
        w1 = usehint_w1_t'(s1_r1 - 5'd1);
      end
    end
  end

endmodule

// File: rtl/usehint_stream.sv
// usehint_stream
// Streaming ML-DSA UseHint: recovers w1' = UseHint(h, r) for NUM_LANES
// coefficients per beat through a two-stage valid/ready pipeline.
// Optional feature macro: USEHINT_OMEGA_CHECK_EN enables the hint-weight
// (omega) check; without it err_omega is tied low.
// Ports:
//   clk, reset       clock, synchronous active-high reset
//   zeroize          synchronous clear, same effect as reset
//   sig_start        pulse: clears beat counter, hint counter, error flag
//   in_valid/ready   input handshake; in_r lanes of REG_SIZE, in_h hint bits
//   out_valid/ready  output handshake; out_w1 lanes of 4 bits
//   out_last         with the final beat of each polynomial
//   poly_done        pulse the cycle after the out_last handshake
//   err_omega        sticky: more than OMEGA hint bits seen
module usehint_stream
  import abr_params_pkg::*;
#(
  parameter int REG_SIZE       = 23,
  parameter int NUM_LANES      = 4,
  parameter int BEATS_PER_POLY = 64
) (
  input  logic                                clk,
  input  logic                                reset,
  input  logic                                zeroize,
  input  logic                                sig_start,
  input  logic                                in_valid,
  output logic                                in_ready,
  input  logic [NUM_LANES*REG_SIZE-1:0]       in_r,
  input  logic [NUM_LANES-1:0]                in_h,
  output logic                                out_valid,
  input  logic                                out_ready,
  output logic [NUM_LANES*MLDSA_W1_WIDTH-1:0] out_w1,
  output logic                                out_last,
  output logic                                poly_done,
  output logic                                err_omega
);

  localparam int BEAT_W = $clog2(BEATS_PER_POLY);
  localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(BEATS_PER_POLY - 1);

  logic clr;
  logic advance;
  logic in_fire;
  logic [BEAT_W-1:0] beat_cnt;
  logic [BEAT_W-1:0] beat_base;

  logic [NUM_LANES-1:0][4:0] lane_r1;
  logic [NUM_LANES-1:0]      lane_pos;
  logic [NUM_LANES*MLDSA_W1_WIDTH-1:0] lane_w1;

  logic                      s1_valid;
  logic [NUM_LANES-1:0][4:0] s1_r1;
  logic [NUM_LANES-1:0]      s1_pos;
  logic [NUM_LANES-1:0]      s1_h;
  logic                      s1_last;

  logic                                s2_valid;
  logic [NUM_LANES*MLDSA_W1_WIDTH-1:0] s2_w1;
  logic                                s2_last;

  assign clr = reset | zeroize;

  // The whole pipe moves when S2 is empty or being drained. S1 may still
  // fill while stalled as long as it is empty, which is exactly in_ready.
  assign advance  = ~s2_valid | out_ready;
  assign in_ready = ~(s1_valid & s2_valid & ~out_ready);
  assign in_fire  = in_valid & in_ready;

  // sig_start clears first, so a beat accepted alongside it is beat 0.
  assign beat_base = sig_start ? '0 : beat_cnt;

  for (genvar i = 0; i < NUM_LANES; i++) begin : g_lane
    usehint_lane #(.REG_SIZE(REG_SIZE)) u_lane (
      .r         (in_r[i*REG_SIZE +: REG_SIZE]),
      .r1        (lane_r1[i]),
      .r0_pos    (lane_pos[i]),
      .s1_r1     (s1_r1[i]),
      .s1_r0_pos (s1_pos[i]),
      .s1_h      (s1_h[i]),
      .w1        (lane_w1[i*MLDSA_W1_WIDTH +: MLDSA_W1_WIDTH])
    );
  end

  always_ff @(posedge clk) begin
    if (clr) begin
      beat_cnt <= '0;
    end else if (in_fire) begin
      beat_cnt <= (beat_base == LAST_BEAT) ? '0 : beat_base + BEAT_W'(1);
    end else if (sig_start) begin
      beat_cnt <= '0;
    end
  end

  always_ff @(posedge clk) begin
    if (clr) begin
      s1_valid <= 1'b0;
      s1_r1    <= '0;
      s1_pos   <= '0;
      s1_h     <= '0;
      s1_last  <= 1'b0;
    end else if (in_ready) begin
      s1_valid <= in_valid;
      if (in_valid) begin
        s1_r1   <= lane_r1;
        s1_pos  <= lane_pos;
        s1_h    <= in_h;
        s1_last <= (beat_base == LAST_BEAT);
      end
    end
  end

  // out_last is gated by s1_valid so it never lingers on an empty slot.
  always_ff @(posedge clk) begin
    if (clr) begin
      s2_valid <= 1'b0;
      s2_w1    <= '0;
      s2_last  <= 1'b0;
    end else if (advance) begin
      s2_valid <= s1_valid;
      s2_last  <= s1_valid & s1_last;
      if (s1_valid) begin
        s2_w1 <= lane_w1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (clr) begin
      poly_done <= 1'b0;
    end else begin
      poly_done <= s2_valid & out_ready & s2_last;
    end
  end

  assign out_valid = s2_valid;
  assign out_w1    = s2_w1;
  assign out_last  = s2_last;

`ifdef USEHINT_OMEGA_CHECK_EN
  logic [6:0] hint_cnt;
  logic [6:0] hint_next;
  logic [7:0] hint_sum;
  logic       err_q;

  // Running hint weight, saturating at 127 so it cannot wrap back below OMEGA.
  always_comb begin
    hint_sum = {1'b0, (sig_start ? 7'd0 : hint_cnt)};
    if (in_fire) begin
      for (int i = 0; i < NUM_LANES; i++) begin
        hint_sum = hint_sum + 8'(in_h[i]);
      end
    end
    hint_next = (hint_sum > 8'd127) ? 7'd127 : hint_sum[6:0];
  end

  always_ff @(posedge clk) begin
    if (clr) begin
      hint_cnt <= '0;
      err_q    <= 1'b0;
    end else begin
      hint_cnt <= hint_next;
      err_q    <= (err_q & ~sig_start) | (hint_next > 7'(MLDSA_OMEGA));
    end
  end

  assign err_omega = err_q;
`else
  assign err_omega = 1'b0;
`endif

endmodule

// File: tb/tb_usehint_stream.sv
// tb_usehint_stream
// Self-checking bench for usehint_stream: a table of hand-computed lane
// vectors, then streaming, backpressure, zeroize and omega sequences checked
// against an arithmetic reference model and a beat scoreboard.
// Build with USEHINT_OMEGA_CHECK_EN defined to expect the omega flag.
module tb_usehint_stream;
  import abr_params_pkg::*;

  localparam int REG_SIZE  = 23;
  localparam int NUM_LANES = 4;
  localparam int BEATS     = 64;
`ifdef USEHINT_OMEGA_CHECK_EN
  localparam bit OMEGA_ON = 1'b1;
`else
  localparam bit OMEGA_ON = 1'b0;
`endif

  logic clk = 1'b0;
  logic reset, zeroize, sig_start, in_valid, in_ready, out_valid, out_ready;
  logic out_last, poly_done, err_omega;
  logic [NUM_LANES*REG_SIZE-1:0] in_r;
  logic [NUM_LANES-1:0]          in_h;
  logic [NUM_LANES*4-1:0]        out_w1;

  int compared   = 0;
  int mismatched = 0;

  typedef struct {
    int unsigned r;
    bit          h;
    logic [3:0]  w1;
  } lane_vec_t;

  typedef struct {
    logic [15:0] w1;
    bit          last;
  } beat_exp_t;

  lane_vec_t vecs[16];
  beat_exp_t sb[$];
  beat_exp_t mon_e;

  int          cyc         = 0;
  int          model_beat  = 0;
  int          stream_idx  = 0;
  int          lat_hs_cyc  = -1;
  bit          lat_arm     = 0;
  bit          lat_done    = 0;
  bit          done_pend   = 0;
  bit          held_valid  = 0;
  logic [15:0] held_w1;
  bit          held_last;
  bit          saw_ready_low = 0;

  always #5 clk = ~clk;

  usehint_stream #(
    .REG_SIZE(REG_SIZE), .NUM_LANES(NUM_LANES), .BEATS_PER_POLY(BEATS)
  ) dut (
    .clk(clk), .reset(reset), .zeroize(zeroize), .sig_start(sig_start),
    .in_valid(in_valid), .in_ready(in_ready), .in_r(in_r), .in_h(in_h),
    .out_valid(out_valid), .out_ready(out_ready), .out_w1(out_w1),
    .out_last(out_last), .poly_done(poly_done), .err_omega(err_omega)
  );

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Straight from the decomposition definition using integer mod/div.
  function automatic logic [3:0] model_w1(input int r, input bit h);
    int r0, r1;
    r0 = r % MLDSA_ALPHA;
    if (r0 > MLDSA_GAMMA2) r0 = r0 - MLDSA_ALPHA;
    r1 = (r - r0) / MLDSA_ALPHA;
    if (r - r0 == MLDSA_Q - 1) begin
      r1 = 0;
      r0 = r0 - 1;
    end
    if (!h) return 4'(r1);
    return (r0 > 0) ? 4'(r1 + 1) : 4'(r1 - 1);
  endfunction

  function automatic logic [22:0] stream_r(input int b, input int i);
    return 23'(((b * 4 + i) * 104729 + 12345) % MLDSA_Q);
  endfunction

  // Holds one beat on the input until it is accepted; returns #1 after the
  // accepting edge with in_valid still high so beats can go back-to-back.
  task automatic applyStimulus(input logic [NUM_LANES*REG_SIZE-1:0] r_word,
                               input logic [NUM_LANES-1:0] h_word);
    bit accepted = 1'b0;
    in_valid = 1'b1;
    in_r     = r_word;
    in_h     = h_word;
    for (int t = 0; t < 50 && !accepted; t++) begin
      @(negedge clk);
      accepted = in_ready;
      @(posedge clk);
      #1;
    end
    if (!accepted) begin
      compared++;
      mismatched++;
      $display("[TB] FAIL accept_timeout: in_ready got 0, expected 1");
    end
  endtask

  task automatic sendStreamBeat(input int b, input logic [NUM_LANES-1:0] h_word);
    logic [NUM_LANES*REG_SIZE-1:0] rw;
    for (int i = 0; i < NUM_LANES; i++) rw[i*REG_SIZE +: REG_SIZE] = stream_r(b, i);
    applyStimulus(rw, h_word);
  endtask

  task automatic waitDrain(input string name);
    for (int t = 0; t < 40 && sb.size() != 0; t++) @(negedge clk);
    checkOutput(name, sb.size(), 0);
  endtask

  // Monitor: samples at negedge; handshakes seen here complete at the next
  // posedge. Scores outputs, stall stability, poly_done and latency.
  always @(negedge clk) begin
    cyc++;
    checkOutput("poly_done", poly_done, done_pend);
    if (reset || zeroize) begin
      sb.delete();
      model_beat = 0;
      done_pend  = 0;
      held_valid = 0;
    end else begin
      if (!in_ready) saw_ready_low = 1;
      if (held_valid) begin
        checkOutput("stall_valid", out_valid, 1);
        checkOutput("stall_w1", out_w1, held_w1);
        checkOutput("stall_last", out_last, held_last);
      end
      held_valid = out_valid && !out_ready;
      held_w1    = out_w1;
      held_last  = out_last;
      done_pend  = out_valid && out_ready && out_last;
      if (lat_arm && !lat_done && lat_hs_cyc >= 0 && out_valid) begin
        checkOutput("latency", cyc - lat_hs_cyc, 2);
        lat_done = 1;
      end
      if (out_valid && out_ready) begin
        if (sb.size() == 0) begin
          compared++;
          mismatched++;
          $display("[TB] FAIL unexpected_beat: got w1 0x%0h, expected no beat", out_w1);
        end else begin
          mon_e = sb.pop_front();
          checkOutput("sb_w1", out_w1, mon_e.w1);
          checkOutput("sb_last", out_last, mon_e.last);
        end
      end
      if (sig_start) model_beat = 0;
      if (in_valid && in_ready) begin
        for (int i = 0; i < NUM_LANES; i++)
          mon_e.w1[i*4 +: 4] = model_w1(int'(in_r[i*REG_SIZE +: REG_SIZE]), in_h[i]);
        mon_e.last = (model_beat == BEATS - 1);
        model_beat = (model_beat + 1) % BEATS;
        sb.push_back(mon_e);
        if (lat_arm && lat_hs_cyc < 0) lat_hs_cyc = cyc;
      end
    end
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation still running, expected completion");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    logic [NUM_LANES*REG_SIZE-1:0] rw;
    logic [NUM_LANES-1:0]          hw;
    bit found;

    reset = 1; zeroize = 0; sig_start = 0; in_valid = 0;
    in_r = '0; in_h = '0; out_ready = 1;

    vecs = '{
      '{32'd0,       1'b0, 4'd0},  '{32'd0,       1'b1, 4'd15},
      '{32'd261888,  1'b0, 4'd0},  '{32'd261888,  1'b1, 4'd1},
      '{32'd261889,  1'b0, 4'd1},  '{32'd261889,  1'b1, 4'd0},
      '{32'd8380416, 1'b0, 4'd0},  '{32'd8380416, 1'b1, 4'd15},
      '{32'd8118529, 1'b0, 4'd0},  '{32'd8118529, 1'b1, 4'd15},
      '{32'd523776,  1'b1, 4'd0},  '{32'd785665,  1'b1, 4'd1},
      '{32'd4000000, 1'b0, 4'd8},  '{32'd4000000, 1'b1, 4'd7},
      '{32'd8118528, 1'b1, 4'd0},  '{32'd7856640, 1'b1, 4'd14}
    };

    repeat (2) @(posedge clk);
    @(negedge clk);
    checkOutput("rst_out_valid", out_valid, 0);
    checkOutput("rst_out_w1", out_w1, 0);
    checkOutput("rst_out_last", out_last, 0);
    checkOutput("rst_poly_done", poly_done, 0);
    checkOutput("rst_err_omega", err_omega, 0);
    checkOutput("rst_in_ready", in_ready, 1);
    @(posedge clk); #1;
    reset = 0;
    sig_start = 1;
    @(posedge clk); #1;
    sig_start = 0;

    $display("[TB] lane vector table");
    for (int b = 0; b < 4; b++) begin
      for (int i = 0; i < NUM_LANES; i++) begin
        rw[i*REG_SIZE +: REG_SIZE] = 23'(vecs[b*4+i].r);
        hw[i] = vecs[b*4+i].h;
      end
      applyStimulus(rw, hw);
      in_valid = 0;
      found = 0;
      for (int t = 0; t < 20 && !found; t++) begin
        @(negedge clk);
        found = out_valid;
      end
      checkOutput($sformatf("table_beat%0d_valid", b), out_valid, 1);
      for (int i = 0; i < NUM_LANES; i++)
        checkOutput($sformatf("table_r%0d_h%0d", vecs[b*4+i].r, vecs[b*4+i].h),
                    out_w1[i*4 +: 4], vecs[b*4+i].w1);
    end
    waitDrain("table_drain");

    $display("[TB] streaming with backpressure");
    @(posedge clk); #1;
    lat_arm = 1; lat_hs_cyc = -1; lat_done = 0;
    saw_ready_low = 0; stream_idx = 0;
    fork
      begin
        for (int b = 0; b < BEATS; b++) begin
          if (b == 0) sig_start = 1;
          sendStreamBeat(b, 4'((b * 5) % 16));
          sig_start = 0;
          stream_idx = b + 1;
        end
        in_valid = 0;
      end
      begin
        wait (stream_idx >= 20);
        @(posedge clk); #1;
        out_ready = 0;
        repeat (3) @(posedge clk);
        #1;
        out_ready = 1;
      end
    join
    waitDrain("stream_drain");
    checkOutput("latency_seen", lat_done, 1);
    checkOutput("bp_in_ready_low", saw_ready_low, 1);
    lat_arm = 0;

    $display("[TB] zeroize mid-polynomial");
    for (int b = 0; b < 30; b++) sendStreamBeat(b + 7, 4'(b % 16));
    in_valid = 0;
    zeroize = 1;
    @(posedge clk); #1;
    zeroize = 0;
    @(negedge clk);
    checkOutput("zer_out_valid", out_valid, 0);
    checkOutput("zer_out_w1", out_w1, 0);
    checkOutput("zer_out_last", out_last, 0);
    checkOutput("zer_poly_done", poly_done, 0);
    checkOutput("zer_err_omega", err_omega, 0);
    checkOutput("zer_in_ready", in_ready, 1);
    @(posedge clk); #1;
    for (int b = 0; b < BEATS; b++) sendStreamBeat(b + 100, 4'(b % 16));
    in_valid = 0;
    waitDrain("zer_poly_drain");

    $display("[TB] omega hint weight");
    sig_start = 1;
    @(posedge clk); #1;
    sig_start = 0;
    for (int b = 0; b < 18; b++) sendStreamBeat(b, 4'b1111);
    sendStreamBeat(18, 4'b0111);
    in_valid = 0;
    repeat (3) @(negedge clk);
    checkOutput("omega_75", err_omega, 0);
    @(posedge clk); #1;
    sendStreamBeat(19, 4'b0001);
    in_valid = 0;
    @(negedge clk);
    checkOutput("omega_76", err_omega, OMEGA_ON);
    @(posedge clk); #1;
    sendStreamBeat(20, 4'b0000);
    in_valid = 0;
    repeat (2) @(negedge clk);
    checkOutput("omega_sticky", err_omega, OMEGA_ON);
    @(posedge clk); #1;
    sig_start = 1;
    @(posedge clk); #1;
    sig_start = 0;
    @(negedge clk);
    checkOutput("omega_cleared", err_omega, 0);
    waitDrain("final_drain");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

// File: doc/usehint_stream.md
# usehint_stream

Streaming ML-DSA UseHint unit for the verify path. It consumes packed coefficients of r = A·z − c·t1·2^d, already reduced to [0, q−1], together with the matching decoded hint bits. It recovers w1' = UseHint(h, r) per coefficient using 4-bit outputs, and feeds the w1 encoder ahead of the challenge-hash recompute. It sits beside the MakeHint logic used on the signing side.

## Interface
- REG_SIZE, 23, coefficient width
- NUM_LANES, 4, coefficients per beat
- BEATS_PER_POLY, 64, beats per polynomial (256 / NUM_LANES)
- clk  in  1  clock
- reset  in  1  synchronous, active-high reset
- zeroize  in  1  synchronous clear, same effect as reset
- sig_start  in  1  one-cycle pulse; clears beat counter, hint counter, error flag
- in_valid  in  1  input beat valid
- in_ready  out  1  input beat accepted when in_valid & in_ready
- in_r  in  NUM_LANES*REG_SIZE  lane i at bits [i*REG_SIZE +: REG_SIZE]
- in_h  in  NUM_LANES  hint bit per lane
- out_valid  out  1  output beat valid
- out_ready  in  1  downstream accept
- out_w1  out  NUM_LANES*4  lane i at [i*4 +: 4]
- out_last  out  1  high with final beat of each polynomial
- poly_done  out  1  one-cycle pulse when the last beat is accepted downstream
- err_omega  out  1  sticky hint-weight violation (see Configuration)

## Operation
- Decomposition uses α = 2·GAMMA2 = 523776.
  - r0 = r mod α; if r0 > GAMMA2, then r0 −= α.
  - r1 = (r − r0)/α.
  - If r − r0 == q−1, then r1 = 0 and r0 = r0 − 1.
- Hint application:
  - h=0 gives w1 = r1.
  - h=1 with r0 > 0 gives w1 = (r1+1) mod 16.
  - h=1 with r0 ≤ 0 gives w1 = (r1−1) mod 16.
- r0 is signed, REG_SIZE+1 bits wide. r1 is computed at 5 bits, and the result is truncated to 4 bits.
- Inputs r ≥ q are not allowed; the output for them is undefined.
- Beat counter runs 0..BEATS_PER_POLY−1 and increments on each input handshake. It wraps to 0 after the last beat.
- out_last is carried down the pipeline with the data of beat BEATS_PER_POLY−1.

## Timing
- Two-stage pipeline.
  - S1 registers the inputs and the decompose results (r1, sign/zero of r0).
  - S2 registers the hint-applied w1.
- Latency is 2 cycles from input handshake to out_valid with no stall.
- Stalls are global: when out_valid & ~out_ready, both stages hold.
- in_ready = ~(S1 full & S2 full & ~out_ready). Full throughput is one beat per cycle.
- out_w1 and out_last hold stable while out_valid & ~out_ready.
- Simultaneous sig_start and handshake: the counters clear first, and the accepted beat counts as beat 0.
- Reset and zeroize give:
  - out_valid=0, out_w1=0, out_last=0, poly_done=0, err_omega=0, in_ready=1.
  - Counters cleared, all pipeline data cleared.
  - Any in-flight beats are dropped.
- poly_done is registered. It asserts the cycle after the out_last handshake.

## Configuration
- USEHINT_OMEGA_CHECK_EN defined:
  - A 7-bit saturating counter adds popcount(in_h) on each input handshake.
  - err_omega is set when the count exceeds OMEGA (75). It stays set until sig_start, reset or zeroize.
  - Data flow is unaffected.
- USEHINT_OMEGA_CHECK_EN not defined:
  - The counter is absent.
  - err_omega is tied to 0.

## Structure
- abr_params_pkg holds MLDSA_Q, MLDSA_GAMMA2, MLDSA_ALPHA (2·GAMMA2), MLDSA_OMEGA and the W1 width (4).
- A usehint_w1_t 4-bit typedef also goes in abr_params_pkg.
- Sub-module usehint_lane is purely combinational (decompose plus hint apply, split at the S1 boundary). It is instantiated NUM_LANES times.
- Handshake, counters and the omega check live in usehint_stream.

## Test plan
- Lane values (h=0 / h=1):
  - r=0: w1=0 / 15.
  - r=261888: w1=0 / 1.
  - r=261889: w1=1 / 0.
- Wrap-around (h=0 / h=1):
  - r=8380416 (q−1): w1=0 / 15.
  - r=8118529 (q−GAMMA2): w1=0 / 15.
- Streaming: 64 back-to-back beats with out_ready=1 → out_valid first high 2 cycles after the first handshake; out_last only on beat 64; poly_done one cycle later; beat counter back at 0.
- Backpressure: out_ready low for 3 cycles mid-stream with in_valid held → in_ready drops, out_w1 stable, no beat lost or duplicated against the reference model.
- Reset/zeroize mid-polynomial at beat 30 → all outputs 0 the next cycle; a following polynomial completes with out_last on its own 64th beat.
- With USEHINT_OMEGA_CHECK_EN: 75 total hint bits → err_omega=0; a 76th → err_omega=1, held until sig_start.
- Without USEHINT_OMEGA_CHECK_EN: the same stimulus → err_omega stays 0.
